// File: rtl/fifo_stat_regs_if.sv
// Register read port between the FIFO status bank and the debug/CSR
// interconnect. The CSR side is the master (issues reads); the status
// bank is the slave (returns registered data one cycle later).
interface fifo_stat_regs_if;
    logic        reg_rd_en;
    logic [3:0]  reg_addr;
    logic [31:0] reg_rdata;
    logic        reg_rvld;
    logic        reg_err;

    modport master (
        output reg_rd_en,
        output reg_addr,
        input  reg_rdata,
        input  reg_rvld,
        input  reg_err
    );

    modport slave (
        input  reg_rd_en,
        input  reg_addr,
        output reg_rdata,
        output reg_rvld,
        output reg_err
    );
endinterface

// File: rtl/fifo_stat_regs.sv
// Status and ECC-error register bank for the SyncFIFO.
// Captures corrected readout data, pointers and error indices each cycle
// (unless frozen), keeps saturating per-source error counters and a sticky
// first-error record, and exposes everything through a registered read port.
//
// Address map (32-bit words, zero-extended):
//   0 fifo_out      1 data_err_idx   2 wr_ptr     3 wr_ptr_err_idx
//   4 rd_ptr        5 rd_ptr_err_idx 6 cnt_data   7 cnt_wr   8 cnt_rd
//   9 sticky {valid[31], src[25:24], idx[ERRDATA-1:0]}
//  10 status {irq[1], freeze[0]}
//  11-15 unmapped: rdata=0, reg_err=1
//
// Optional feature: define FIFO_STAT_IRQ_EN to build the threshold interrupt.
// Without it irq is tied low and err_thresh is ignored.
module fifo_stat_regs #(
    parameter int ADDR    = 10,
    parameter int ERRPTR  = 4,
    parameter int WIDTH   = 32,
    parameter int ERRDATA = 6,
    parameter int CNTW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    fifo_out,
    input  logic [ERRDATA-1:0]  data_err_idx,
    input  logic [ADDR-1:0]     wr_ptr,
    input  logic [ERRPTR-1:0]   wr_ptr_err_idx,
    input  logic [ADDR-1:0]     rd_ptr,
    input  logic [ERRPTR-1:0]   rd_ptr_err_idx,
    input  logic                freeze,
    input  logic                clr,
    input  logic [CNTW-1:0]     err_thresh,
    fifo_stat_regs_if.slave     reg_bus,
    output logic                irq
);

    typedef enum logic [1:0] {
        SRC_DATA = 2'd0,
        SRC_WR   = 2'd1,
        SRC_RD   = 2'd2
    } src_e;

    localparam logic [CNTW-1:0] CNT_MAX   = '1;
    localparam logic [3:0]      ADDR_LAST = 4'd10;

    // Live capture registers
    logic [WIDTH-1:0]   live_fifo_out;
    logic [ERRDATA-1:0] live_data_err_idx;
    logic [ADDR-1:0]    live_wr_ptr;
    logic [ERRPTR-1:0]  live_wr_ptr_err_idx;
    logic [ADDR-1:0]    live_rd_ptr;
    logic [ERRPTR-1:0]  live_rd_ptr_err_idx;

    // Error counters and their next-state values
    logic [CNTW-1:0] cnt_data, cnt_wr, cnt_rd;
    logic [CNTW-1:0] cnt_data_nxt, cnt_wr_nxt, cnt_rd_nxt;

    // Sticky first-error record
    logic               stk_valid, stk_valid_nxt;
    src_e               stk_src, stk_src_nxt;
    logic [ERRDATA-1:0] stk_idx, stk_idx_nxt;

    // Per-source error strobes for this cycle
    logic hit_data, hit_wr, hit_rd;

    // Read mux output
    logic [31:0] rd_word;
    logic        rd_bad;

    // Error strobes: any nonzero index means an error this cycle
    always_comb begin
        hit_data = (data_err_idx != '0);
        hit_wr   = (wr_ptr_err_idx != '0);
        hit_rd   = (rd_ptr_err_idx != '0);
    end

    // Live registers follow their inputs unless frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_fifo_out       <= '0;
            live_data_err_idx   <= '0;
            live_wr_ptr         <= '0;
            live_wr_ptr_err_idx <= '0;
            live_rd_ptr         <= '0;
            live_rd_ptr_err_idx <= '0;
        end else if (!freeze) begin
            live_fifo_out       <= fifo_out;
            live_data_err_idx   <= data_err_idx;
            live_wr_ptr         <= wr_ptr;
            live_wr_ptr_err_idx <= wr_ptr_err_idx;
            live_rd_ptr         <= rd_ptr;
            live_rd_ptr_err_idx <= rd_ptr_err_idx;
        end
    end

    // Counter update: clr zeroes the old value first, so an error on the
    // clr edge lands as a count of 1; increments stop at all-ones.
    function automatic logic [CNTW-1:0] cnt_step(
        input logic [CNTW-1:0] cur,
        input logic            hit,
        input logic            clear
    );
        logic [CNTW-1:0] base;
        base = clear ? '0 : cur;
        if (hit && (base != CNT_MAX))
            base = base + CNTW'(1);
        return base;
    endfunction

    // Next-state values for the three saturating counters
    always_comb begin
        cnt_data_nxt = cnt_step(cnt_data, hit_data, clr);
        cnt_wr_nxt   = cnt_step(cnt_wr,   hit_wr,   clr);
        cnt_rd_nxt   = cnt_step(cnt_rd,   hit_rd,   clr);
    end

    // Error counters keep counting regardless of freeze
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_data <= '0;
            cnt_wr   <= '0;
            cnt_rd   <= '0;
        end else begin
            cnt_data <= cnt_data_nxt;
            cnt_wr   <= cnt_wr_nxt;
            cnt_rd   <= cnt_rd_nxt;
        end
    end

    // Sticky record next state: clr empties the record before the
    // first-error check, so an error on the clr edge is captured.
    always_comb begin
        stk_valid_nxt = clr ? 1'b0 : stk_valid;
        stk_src_nxt   = clr ? SRC_DATA : stk_src;
        stk_idx_nxt   = clr ? '0 : stk_idx;
        if (!stk_valid_nxt) begin
            if (hit_data) begin
                stk_valid_nxt = 1'b1;
                stk_src_nxt   = SRC_DATA;
                stk_idx_nxt   = data_err_idx;
            end else if (hit_wr) begin
                stk_valid_nxt = 1'b1;
                stk_src_nxt   = SRC_WR;
                stk_idx_nxt   = ERRDATA'(wr_ptr_err_idx);
            end else if (hit_rd) begin
                stk_valid_nxt = 1'b1;
                stk_src_nxt   = SRC_RD;
                stk_idx_nxt   = ERRDATA'(rd_ptr_err_idx);
            end
        end
    end

    // Sticky first-error record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_valid <= 1'b0;
            stk_src   <= SRC_DATA;
            stk_idx   <= '0;
        end else begin
            stk_valid <= stk_valid_nxt;
            stk_src   <= stk_src_nxt;
            stk_idx   <= stk_idx_nxt;
        end
    end

`ifdef FIFO_STAT_IRQ_EN
    logic irq_set;

    // Threshold compare on post-clear counter values
    always_comb begin
        irq_set = (err_thresh != '0) &&
                  ((cnt_data_nxt >= err_thresh) ||
                   (cnt_wr_nxt   >= err_thresh) ||
                   (cnt_rd_nxt   >= err_thresh));
    end

    // Sticky interrupt: cleared by clr, but re-set on the same edge if the
    // post-clear counts still meet the threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= (irq & ~clr) | irq_set;
    end
`else
    logic unused_err_thresh;
    assign unused_err_thresh = ^err_thresh;
    assign irq = 1'b0;
`endif

    // Address decode for the read port (pre-edge register values)
    always_comb begin
        rd_word = '0;
        rd_bad  = (reg_bus.reg_addr > ADDR_LAST);
        case (reg_bus.reg_addr)
            4'd0:  rd_word = 32'(live_fifo_out);
            4'd1:  rd_word = 32'(live_data_err_idx);
            4'd2:  rd_word = 32'(live_wr_ptr);
            4'd3:  rd_word = 32'(live_wr_ptr_err_idx);
            4'd4:  rd_word = 32'(live_rd_ptr);
            4'd5:  rd_word = 32'(live_rd_ptr_err_idx);
            4'd6:  rd_word = 32'(cnt_data);
            4'd7:  rd_word = 32'(cnt_wr);
            4'd8:  rd_word = 32'(cnt_rd);
            4'd9: begin
                rd_word[31]           = stk_valid;
                rd_word[25:24]        = stk_src;
                rd_word[ERRDATA-1:0]  = stk_idx;
            end
            4'd10: rd_word = {30'd0, irq, freeze};
            default: rd_word = '0;
        endcase
    end

    // Registered read response; rdata holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_bus.reg_rdata <= '0;
            reg_bus.reg_rvld  <= 1'b0;
            reg_bus.reg_err   <= 1'b0;
        end else if (reg_bus.reg_rd_en) begin
            reg_bus.reg_rdata <= rd_word;
            reg_bus.reg_rvld  <= 1'b1;
            reg_bus.reg_err   <= rd_bad;
        end else begin
            reg_bus.reg_rvld  <= 1'b0;
            reg_bus.reg_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_stat_regs.sv
// Self-checking bench for fifo_stat_regs (CNTW=4 so saturation is reachable).
// A behavioural model tracks the register contents as plain integers; each
// scenario task drives stimulus and compares DUT outputs against it.
module tb_fifo_stat_regs;

    localparam int ADDR    = 10;
    localparam int ERRPTR  = 4;
    localparam int WIDTH   = 32;
    localparam int ERRDATA = 6;
    localparam int CNTW    = 4;
    localparam int CMAX    = 15;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [WIDTH-1:0]   fifo_out;
    logic [ERRDATA-1:0] data_err_idx;
    logic [ADDR-1:0]    wr_ptr;
    logic [ERRPTR-1:0]  wr_ptr_err_idx;
    logic [ADDR-1:0]    rd_ptr;
    logic [ERRPTR-1:0]  rd_ptr_err_idx;
    logic               freeze;
    logic               clr;
    logic [CNTW-1:0]    err_thresh;
    logic               irq;

    fifo_stat_regs_if bus ();

    fifo_stat_regs #(
        .ADDR    (ADDR),
        .ERRPTR  (ERRPTR),
        .WIDTH   (WIDTH),
        .ERRDATA (ERRDATA),
        .CNTW    (CNTW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_out       (fifo_out),
        .data_err_idx   (data_err_idx),
        .wr_ptr         (wr_ptr),
        .wr_ptr_err_idx (wr_ptr_err_idx),
        .rd_ptr         (rd_ptr),
        .rd_ptr_err_idx (rd_ptr_err_idx),
        .freeze         (freeze),
        .clr            (clr),
        .err_thresh     (err_thresh),
        .reg_bus        (bus.slave),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_live [6];
    int          m_cnt  [3];
    bit          m_svalid;
    int          m_ssrc;
    int          m_sidx;
    bit          m_irq;

    // Expected read-port outputs after the most recent step
    logic [31:0] exp_rdata;
    bit          exp_rvld;
    bit          exp_err;

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] w;
        w = 32'd0;
        if (a <= 5) w = m_live[a];
        else if (a <= 8) w = 32'(m_cnt[a - 6]);
        else if (a == 9) begin
            if (m_svalid) w = 32'h8000_0000 + 32'(m_ssrc * (1 << 24)) + 32'(m_sidx);
        end else if (a == 10) w = 32'(m_irq) * 2 + 32'(freeze);
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_live[i] = 32'd0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_svalid  = 0;
        m_ssrc    = 0;
        m_sidx    = 0;
        m_irq     = 0;
        exp_rdata = 32'd0;
        exp_rvld  = 0;
        exp_err   = 0;
    endtask

    task automatic model_edge();
        int errs [3];
        errs[0] = int'(data_err_idx);
        errs[1] = int'(wr_ptr_err_idx);
        errs[2] = int'(rd_ptr_err_idx);
        if (!freeze) begin
            m_live[0] = 32'(fifo_out);
            m_live[1] = 32'(data_err_idx);
            m_live[2] = 32'(wr_ptr);
            m_live[3] = 32'(wr_ptr_err_idx);
            m_live[4] = 32'(rd_ptr);
            m_live[5] = 32'(rd_ptr_err_idx);
        end
        for (int i = 0; i < 3; i++) begin
            if (clr) m_cnt[i] = 0;
            if (errs[i] != 0 && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        end
        if (clr) m_svalid = 0;
        if (!m_svalid) begin
            for (int i = 0; i < 3; i++) begin
                if (!m_svalid && errs[i] != 0) begin
                    m_svalid = 1;
                    m_ssrc   = i;
                    m_sidx   = errs[i];
                end
            end
        end
`ifdef FIFO_STAT_IRQ_EN
        if (clr) m_irq = 0;
        if (err_thresh != 0) begin
            for (int i = 0; i < 3; i++)
                if (m_cnt[i] >= int'(err_thresh)) m_irq = 1;
        end
`else
        m_irq = 0;
`endif
    endtask

    // One clock: record what the read port must return, then advance model
    task automatic step();
        exp_rvld = bus.reg_rd_en;
        if (bus.reg_rd_en) begin
            exp_err   = (bus.reg_addr > 4'd10);
            exp_rdata = model_read(int'(bus.reg_addr));
        end else begin
            exp_err = 0;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input int a);
        bus.reg_rd_en = 1'b1;
        bus.reg_addr  = 4'(a);
        step();
        bus.reg_rd_en = 1'b0;
    endtask

    task automatic quiet_inputs();
        data_err_idx   = '0;
        wr_ptr_err_idx = '0;
        rd_ptr_err_idx = '0;
        clr            = 1'b0;
        freeze         = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_out = '0; wr_ptr = '0; rd_ptr = '0; err_thresh = '0;
        quiet_inputs();
        bus.reg_rd_en = 1'b0;
        bus.reg_addr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.reg_rvld !== 1'b0 || bus.reg_rdata !== 32'd0 || bus.reg_err !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rvld=%b rdata=%h err=%b irq=%b, want all 0",
                     bus.reg_rvld, bus.reg_rdata, bus.reg_err, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a <= 10; a++) begin
            rd(a);
            checks++;
            if (bus.reg_rvld !== 1'b1 || bus.reg_rdata !== 32'd0 || bus.reg_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_read[%0d]: rvld=%b rdata=%h err=%b, want 1/0/0",
                         a, bus.reg_rvld, bus.reg_rdata, bus.reg_err);
            end
        end
        rd(12);
        checks++;
        if (bus.reg_rvld !== 1'b1 || bus.reg_rdata !== 32'd0 || bus.reg_err !== 1'b1) begin
            failures++;
            $display("FAIL reset_bad_addr: rvld=%b rdata=%h err=%b, want 1/0/1",
                     bus.reg_rvld, bus.reg_rdata, bus.reg_err);
        end
        step();
        checks++;
        if (bus.reg_rvld !== 1'b0 || bus.reg_err !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_read: rvld=%b err=%b, want 0/0", bus.reg_rvld, bus.reg_err);
        end
    endtask

    task automatic test_capture();
        fifo_out = 32'hDEAD_BEEF;
        wr_ptr   = 10'h155;
        step();
        rd(0);
        checks++;
        if (bus.reg_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL capture_fifo_out: got %h want deadbeef", bus.reg_rdata);
        end
        rd(2);
        checks++;
        if (bus.reg_rdata !== 32'h155) begin
            failures++;
            $display("FAIL capture_wr_ptr: got %h want 155", bus.reg_rdata);
        end
        freeze   = 1'b1;
        fifo_out = '0;
        wr_ptr   = '0;
        step();
        rd(0);
        checks++;
        if (bus.reg_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL freeze_fifo_out: got %h want deadbeef", bus.reg_rdata);
        end
        rd(2);
        checks++;
        if (bus.reg_rdata !== 32'h155) begin
            failures++;
            $display("FAIL freeze_wr_ptr: got %h want 155", bus.reg_rdata);
        end
        rd(10);
        checks++;
        if (bus.reg_rdata !== 32'd1) begin
            failures++;
            $display("FAIL status_freeze: got %h want 1", bus.reg_rdata);
        end
        freeze = 1'b0;
        step();
        rd(0);
        checks++;
        if (bus.reg_rdata !== 32'd0) begin
            failures++;
            $display("FAIL unfreeze_capture: got %h want 0", bus.reg_rdata);
        end
    endtask

    task automatic test_counters();
        quiet_inputs();
        pulse_clr();
        data_err_idx   = 6'd5;
        rd_ptr_err_idx = 4'd2;
        step();
        rd_ptr_err_idx = '0;
        step();
        step();
        data_err_idx = '0;
        rd(6);
        checks++;
        if (bus.reg_rdata !== 32'd3) begin
            failures++;
            $display("FAIL cnt_data: got %0d want 3", bus.reg_rdata);
        end
        rd(8);
        checks++;
        if (bus.reg_rdata !== 32'd1) begin
            failures++;
            $display("FAIL cnt_rd: got %0d want 1", bus.reg_rdata);
        end
        rd(9);
        checks++;
        if (bus.reg_rdata !== 32'h8000_0005) begin
            failures++;
            $display("FAIL sticky_data: got %h want 80000005", bus.reg_rdata);
        end
        pulse_clr();
        for (int a = 6; a <= 9; a++) begin
            rd(a);
            checks++;
            if (bus.reg_rdata !== 32'd0) begin
                failures++;
                $display("FAIL after_clr[%0d]: got %h want 0", a, bus.reg_rdata);
            end
        end
        // read issued on the same edge as an error sees the old count
        data_err_idx = 6'd1;
        rd(6);
        data_err_idx = '0;
        checks++;
        if (bus.reg_rdata !== 32'd0) begin
            failures++;
            $display("FAIL pre_increment_read: got %0d want 0", bus.reg_rdata);
        end
        rd(6);
        checks++;
        if (bus.reg_rdata !== 32'd1) begin
            failures++;
            $display("FAIL post_increment_read: got %0d want 1", bus.reg_rdata);
        end
    endtask

    task automatic test_saturation();
        quiet_inputs();
        pulse_clr();
        wr_ptr_err_idx = 4'd3;
        repeat (20) step();
        wr_ptr_err_idx = '0;
        rd(7);
        checks++;
        if (bus.reg_rdata !== 32'd15) begin
            failures++;
            $display("FAIL cnt_wr_saturate: got %0d want 15", bus.reg_rdata);
        end
        rd(9);
        checks++;
        if (bus.reg_rdata !== 32'h8100_0003) begin
            failures++;
            $display("FAIL sticky_wr: got %h want 81000003", bus.reg_rdata);
        end
    endtask

    task automatic test_clr_collision();
        quiet_inputs();
        rd_ptr_err_idx = 4'd9;
        step();
        data_err_idx   = 6'd7;
        rd_ptr_err_idx = '0;
        step();
        step();
        clr          = 1'b1;
        data_err_idx = 6'd1;
        step();
        clr          = 1'b0;
        data_err_idx = '0;
        rd(6);
        checks++;
        if (bus.reg_rdata !== 32'd1) begin
            failures++;
            $display("FAIL clr_collision_cnt: got %0d want 1", bus.reg_rdata);
        end
        rd(9);
        checks++;
        if (bus.reg_rdata !== 32'h8000_0001) begin
            failures++;
            $display("FAIL clr_collision_sticky: got %h want 80000001", bus.reg_rdata);
        end
        rd(8);
        checks++;
        if (bus.reg_rdata !== 32'd0) begin
            failures++;
            $display("FAIL clr_collision_cnt_rd: got %0d want 0", bus.reg_rdata);
        end
    endtask

    task automatic test_irq();
        bit want;
        quiet_inputs();
        err_thresh = 4'd0;
        pulse_clr();
        err_thresh   = 4'd4;
        data_err_idx = 6'd2;
        for (int k = 1; k <= 4; k++) begin
            step();
`ifdef FIFO_STAT_IRQ_EN
            want = (k == 4);
`else
            want = 0;
`endif
            checks++;
            if (irq !== want) begin
                failures++;
                $display("FAIL irq_rise[%0d]: got %b want %b", k, irq, want);
            end
        end
        data_err_idx = '0;
        repeat (3) step();
        rd(10);
`ifdef FIFO_STAT_IRQ_EN
        want = 1;
`else
        want = 0;
`endif
        checks++;
        if (irq !== want || bus.reg_rdata !== {30'd0, want, 1'b0}) begin
            failures++;
            $display("FAIL irq_hold: irq=%b status=%h want irq %b", irq, bus.reg_rdata, want);
        end
        pulse_clr();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clr: got %b want 0", irq);
        end
        // clr and an error together with threshold 1: post-clear count 1 meets it
        err_thresh   = 4'd1;
        clr          = 1'b1;
        data_err_idx = 6'd1;
        step();
        clr          = 1'b0;
        data_err_idx = '0;
`ifdef FIFO_STAT_IRQ_EN
        want = 1;
`else
        want = 0;
`endif
        checks++;
        if (irq !== want) begin
            failures++;
            $display("FAIL irq_clr_collision: got %b want %b", irq, want);
        end
        err_thresh = 4'd0;
        pulse_clr();
        wr_ptr_err_idx = 4'd1;
        repeat (16) step();
        wr_ptr_err_idx = '0;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_thresh_zero: got %b want 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        quiet_inputs();
        fifo_out = 32'h1234_5678;
        rd_ptr   = 10'h2A5;
        step();
        bus.reg_rd_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.reg_addr = 4'(a);
            step();
            checks++;
            if (bus.reg_rvld !== 1'b1 || bus.reg_rdata !== exp_rdata || bus.reg_err !== exp_err) begin
                failures++;
                $display("FAIL back_to_back[%0d]: rvld=%b rdata=%h err=%b want 1/%h/%b",
                         a, bus.reg_rvld, bus.reg_rdata, bus.reg_err, exp_rdata, exp_err);
            end
        end
        bus.reg_rd_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        rd(6);
        checks++;
        if (bus.reg_rvld !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: rvld=%b want 1", bus.reg_rvld);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.reg_rvld !== 1'b0 || bus.reg_rdata !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: rvld=%b rdata=%h irq=%b want 0/0/0",
                     bus.reg_rvld, bus.reg_rdata, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int bad_cnt;
        bad_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            fifo_out       = WIDTH'($urandom);
            wr_ptr         = ADDR'($urandom);
            rd_ptr         = ADDR'($urandom);
            data_err_idx   = ($urandom_range(0, 5) == 0) ? ERRDATA'($urandom) : '0;
            wr_ptr_err_idx = ($urandom_range(0, 5) == 0) ? ERRPTR'($urandom) : '0;
            rd_ptr_err_idx = ($urandom_range(0, 5) == 0) ? ERRPTR'($urandom) : '0;
            freeze         = ($urandom_range(0, 3) == 0);
            clr            = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 40) == 0) err_thresh = CNTW'($urandom);
            bus.reg_rd_en  = ($urandom_range(0, 2) != 0);
            bus.reg_addr   = 4'($urandom);
            step();
            checks++;
            if (bus.reg_rvld !== exp_rvld || bus.reg_err !== exp_err ||
                bus.reg_rdata !== exp_rdata || irq !== m_irq) begin
                failures++;
                bad_cnt++;
                if (bad_cnt <= 10)
                    $display("FAIL random[%0d]: rvld=%b err=%b rdata=%h irq=%b want %b/%b/%h/%b",
                             n, bus.reg_rvld, bus.reg_err, bus.reg_rdata, irq,
                             exp_rvld, exp_err, exp_rdata, m_irq);
            end
        end
        bus.reg_rd_en = 1'b0;
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_counters();
        test_saturation();
        test_clr_collision();
        test_irq();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stat_regs.md
# fifo_stat_regs

Parametrised status and ECC-error register bank for the SyncFIFO. Every cycle it captures the corrected readout data, pointers and error indices. It also keeps saturating per-source error counters and a sticky first-error record. All of this is exposed through a registered read port and sits between the FIFO/ECC datapath and the debug/CSR interconnect. This block supersedes the plain capture register stage: it adds freeze, error accounting, an addressable readout and an optional threshold interrupt.

## Interface
- ADDR, 10, pointer width
- ERRPTR, 4, pointer error index width
- WIDTH, 32, data width; must be ≤ 32
- ERRDATA, 6, data error index width
- CNTW, 16, error counter width, 1..32
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_out  in  WIDTH  corrected FIFO readout data
- data_err_idx  in  ERRDATA  data error index; nonzero means an error was detected this cycle
- wr_ptr  in  ADDR  corrected write pointer
- wr_ptr_err_idx  in  ERRPTR  write pointer error index; nonzero means an error
- rd_ptr  in  ADDR  corrected read pointer
- rd_ptr_err_idx  in  ERRPTR  read pointer error index; nonzero means an error
- freeze  in  1  level; holds the live registers
- clr  in  1  pulse; clears the counters, the sticky record and irq
- err_thresh  in  CNTW  interrupt threshold; 0 disables the interrupt
- reg_rd_en  in  1  read request
- reg_addr  in  4  read address
- reg_rdata  out  32  read data, zero-extended
- reg_rvld  out  1  read data valid
- reg_err  out  1  address out of range, qualifies reg_rvld
- irq  out  1  sticky threshold interrupt

## Operation
- Live registers (addr 0–5: fifo_out, data_err_idx, wr_ptr, wr_ptr_err_idx, rd_ptr, rd_ptr_err_idx):
  - Load their input at every clock edge while freeze=0.
  - Hold their value while freeze=1.
- Counters, addr 6/7/8: cnt_data, cnt_wr, cnt_rd.
  - Each increments by 1 on any edge where its index input is nonzero.
  - Counting continues regardless of freeze.
  - Each saturates at 2^CNTW−1 and never wraps.
- Sticky record, addr 9: {valid[31], src[25:24], idx[ERRDATA−1:0]}.
  - src encoding: 0=data, 1=wr_ptr, 2=rd_ptr.
  - Loads on the first error while valid=0.
  - If several errors occur in the same cycle, priority is data > wr_ptr > rd_ptr.
  - Once valid=1, the record holds until clr.
- Status, addr 10: {irq[1], freeze[0]}.
- clr:
  - Zeroes the counters, the sticky record and irq.
  - If an error occurs on the same edge as clr, the affected counter loads 1 and the sticky record captures that error. clr wins over the old state but the new event is kept.
  - clr does not affect the live registers.
- Read port:
  - reg_rd_en samples reg_addr; reg_rdata/reg_rvld follow on the next edge.
  - Reads are non-destructive.
  - Addr 11–15 return reg_rdata=0 with reg_err=1.
  - When reg_rd_en=0, reg_rvld=0 and reg_rdata holds its last value.
- Back-to-back reads on consecutive cycles are supported at one per cycle.

## Timing
- Reset: all live registers, counters, the sticky record, reg_rdata, reg_rvld, reg_err and irq are 0.
- Live capture latency is 1 cycle: an input at edge N is readable from the register at N+1.
- Counter visibility: an error at edge N increments the counter at N. A read issued in the same cycle returns the pre-increment value.
- Read latency is 1 cycle, fixed; there is no backpressure.
- Asserting rst_n low mid-read aborts the read: reg_rvld=0 immediately (asynchronous).
- When freeze deasserts, capture resumes at the next edge.

## Configuration
- FIFO_STAT_IRQ_EN defined:
  - irq sets on the edge any counter becomes ≥ err_thresh, provided err_thresh≠0.
  - irq stays high until clr or reset.
  - If clr and the set condition occur on the same edge, irq=1 only if the post-clear counter value (0 or 1) is still ≥ err_thresh.
- FIFO_STAT_IRQ_EN undefined:
  - irq is tied to 0 and the threshold logic is absent.
  - Status bit 1 reads 0.
  - err_thresh is ignored.

## Test plan
- Reset, then read addr 0–10 → all return 0, reg_rvld=1 one cycle after each reg_rd_en; addr 12 → reg_rdata=0, reg_err=1.
- fifo_out=0xDEADBEEF, wr_ptr=0x155 for 1 cycle, then read addr 0 and 2 → 0xDEADBEEF and 0x155; with freeze=1 while the inputs change to 0x0 → reads still return the old values.
- data_err_idx=5 for 3 cycles, rd_ptr_err_idx=2 in the first of those cycles → cnt_data=3, cnt_rd=1, sticky={valid=1, src=0, idx=5}; clr then → all 0.
- CNTW=4, wr_ptr_err_idx nonzero for 20 cycles → cnt_wr=15 (saturated, no wrap).
- clr on the same edge as data_err_idx=1 → cnt_data=1, sticky valid with src=0.
- FIFO_STAT_IRQ_EN defined, err_thresh=4, 4 data errors → irq rises on the 4th error edge and stays high until clr; with the macro undefined → irq remains 0.
